// File: rtl/cgra_sched_pkg.sv
// Types and widths shared between the CTA scheduler and the e-block in-flight queue.
package cgra_sched_pkg;

   localparam int MAX_NUM_CTA     = 4;
   localparam int CTA_ID_WIDTH    = $clog2(MAX_NUM_CTA);
   localparam int PC_WIDTH        = 32;
   localparam int MAX_EBLOCK      = 8;
   localparam int EBLOCK_ID_WIDTH = $clog2(MAX_EBLOCK);
   localparam int OCC_WIDTH       = EBLOCK_ID_WIDTH + 1;

   typedef logic [CTA_ID_WIDTH-1:0]    cta_id_t;
   typedef logic [PC_WIDTH-1:0]        pc_t;
   typedef logic [EBLOCK_ID_WIDTH-1:0] eb_id_t;
   typedef logic [OCC_WIDTH-1:0]       occ_t;

   // skipped: a squashed entry stepped over by dispatch without ever issuing
   typedef struct packed {
      logic    valid;
      logic    dispatched;
      logic    skipped;
      logic    done;
      logic    squash;
      logic    mispredict;
      logic    predicted;
      cta_id_t cta_id;
      pc_t     pc;
      eb_id_t  eblock_id;
   } eblock_entry_t;

endpackage

// File: rtl/eblock_inflight_queue_if.sv
// Scheduler / fetch / writeback / commit signal bundle of the e-block in-flight queue.
interface eblock_inflight_queue_if;
   import cgra_sched_pkg::*;

   logic    in_valid;
   logic    in_ready;
   cta_id_t in_cta_id;
   pc_t     in_pc;
   eb_id_t  in_eblock_id;
   logic    in_predicted;

   logic    disp_valid;
   logic    disp_ready;
   cta_id_t disp_cta_id;
   pc_t     disp_pc;
   eb_id_t  disp_eblock_id;

   logic    done_valid;
   eb_id_t  done_eblock_id;
   logic    done_mispredict;

   logic    commit_valid;
   eb_id_t  commit_eblock_id;
   cta_id_t commit_cta_id;
   logic    commit_squashed;

   logic    mispredict_valid;
   cta_id_t mispredict_cta_id;
   occ_t    occupancy;

   modport slave (
      input  in_valid, in_cta_id, in_pc, in_eblock_id, in_predicted,
      input  disp_ready, done_valid, done_eblock_id, done_mispredict,
      output in_ready, disp_valid, disp_cta_id, disp_pc, disp_eblock_id,
      output commit_valid, commit_eblock_id, commit_cta_id, commit_squashed,
      output mispredict_valid, mispredict_cta_id, occupancy
   );

   modport master (
      output in_valid, in_cta_id, in_pc, in_eblock_id, in_predicted,
      output disp_ready, done_valid, done_eblock_id, done_mispredict,
      input  in_ready, disp_valid, disp_cta_id, disp_pc, disp_eblock_id,
      input  commit_valid, commit_eblock_id, commit_cta_id, commit_squashed,
      input  mispredict_valid, mispredict_cta_id, occupancy
   );

endinterface

// File: rtl/eblock_inflight_queue.sv
// In-order e-block tracking queue: allocate, dispatch in order, complete out of order,
// retire in allocation order, and squash younger same-CTA work on a mispredict.
module eblock_inflight_queue
   import cgra_sched_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   eblock_inflight_queue_if.slave  q
);

   eblock_entry_t ent_q [MAX_EBLOCK];
   eblock_entry_t ent_d [MAX_EBLOCK];
   eb_id_t        head_q, head_d, disp_q, disp_d, tail_q, tail_d;
   occ_t          occ_q, occ_d;

   eblock_entry_t head_e, disp_e;
   logic          disp_pend, disp_vld, retire, mp, enq;

   assign head_e    = ent_q[head_q];
   assign disp_e    = ent_q[disp_q];
   assign disp_pend = disp_e.valid && !disp_e.dispatched;
   assign disp_vld  = disp_pend && !disp_e.squash;
   assign retire    = head_e.valid && (head_e.done || (head_e.squash && head_e.skipped));
   assign mp        = retire && head_e.done && head_e.mispredict && head_e.predicted && !head_e.squash;
   assign enq       = q.in_valid && q.in_ready;

   // in_ready looks at pre-retire occupancy so a full queue never bypasses a retiring slot
   assign q.in_ready          = (occ_q != OCC_WIDTH'(MAX_EBLOCK));
   assign q.occupancy         = occ_q;
   assign q.disp_valid        = disp_vld;
   assign q.disp_cta_id       = disp_vld ? disp_e.cta_id    : '0;
   assign q.disp_pc           = disp_vld ? disp_e.pc        : '0;
   assign q.disp_eblock_id    = disp_vld ? disp_e.eblock_id : '0;
   assign q.commit_valid      = retire;
   assign q.commit_eblock_id  = retire ? head_e.eblock_id : '0;
   assign q.commit_cta_id     = retire ? head_e.cta_id    : '0;
   assign q.commit_squashed   = retire && head_e.squash;
   assign q.mispredict_valid  = mp;
   assign q.mispredict_cta_id = mp ? head_e.cta_id : '0;

   always_comb begin
      ent_d  = ent_q;
      head_d = head_q;
      disp_d = disp_q;
      tail_d = tail_q;
      occ_d  = occ_q + OCC_WIDTH'(enq) - OCC_WIDTH'(retire);

      // completions only count for entries actually issued and still outstanding
      if (q.done_valid) begin
         for (int i = 0; i < MAX_EBLOCK; i++) begin
            if (ent_q[i].valid && ent_q[i].dispatched && !ent_q[i].skipped &&
                !ent_q[i].done && ent_q[i].eblock_id == q.done_eblock_id) begin
               ent_d[i].done       = 1'b1;
               ent_d[i].mispredict = q.done_mispredict;
            end
         end
      end

      if (disp_pend && (disp_e.squash || q.disp_ready)) begin
         ent_d[disp_q].dispatched = 1'b1;
         ent_d[disp_q].skipped    = disp_e.squash;
         disp_d                   = disp_q + eb_id_t'(1);
      end

      // everything still live behind the head is younger
      if (mp) begin
         for (int i = 0; i < MAX_EBLOCK; i++) begin
            if (ent_q[i].valid && EBLOCK_ID_WIDTH'(i) != head_q &&
                ent_q[i].cta_id == head_e.cta_id)
               ent_d[i].squash = 1'b1;
         end
      end

      if (retire) begin
         ent_d[head_q] = '0;
         head_d        = head_q + eb_id_t'(1);
      end

      if (enq) begin
         ent_d[tail_q]           = '0;
         ent_d[tail_q].valid     = 1'b1;
         ent_d[tail_q].predicted = q.in_predicted;
         ent_d[tail_q].cta_id    = q.in_cta_id;
         ent_d[tail_q].pc        = q.in_pc;
         ent_d[tail_q].eblock_id = q.in_eblock_id;
         ent_d[tail_q].squash    = mp && (q.in_cta_id == head_e.cta_id);
         tail_d                  = tail_q + eb_id_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_EBLOCK; i++) ent_q[i] <= '0;
         head_q <= '0;
         disp_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         ent_q  <= ent_d;
         head_q <= head_d;
         disp_q <= disp_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

endmodule

// File: tb/tb_eblock_inflight_queue.sv
// Scoreboard bench for eblock_inflight_queue against a queue-based reference model.
module tb_eblock_inflight_queue;
   import cgra_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eblock_inflight_queue_if qif();
   eblock_inflight_queue dut (.clk(clk), .rst(rst), .q(qif));

   typedef struct {
      int          cta;
      logic [31:0] pc;
      int          id;
      bit          pred, mis, squash, disp, skip, done;
   } ment_t;

   typedef struct {
      bit          rdy;
      int          occ;
      bit          dv;
      int          dcta;
      logic [31:0] dpc;
      int          did;
      bit          mv;
      int          mcta;
   } st_t;

   typedef struct {
      int id;
      int cta;
      bit sq;
   } cm_t;

   ment_t mq[$];
   st_t   stq[$];
   cm_t   cq[$];
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 0;
   int    nid    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs each cycle against expectations pushed by the driver.
   initial begin : monitor
      st_t s;
      cm_t c;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            if (stq.size() > 0) begin
               s = stq.pop_front();
               chk("in_ready", qif.in_ready, s.rdy);
               chk("occupancy", qif.occupancy, s.occ);
               chk("disp_valid", qif.disp_valid, s.dv);
               if (s.dv) begin
                  chk("disp_cta_id", qif.disp_cta_id, s.dcta);
                  chk("disp_pc", qif.disp_pc, s.dpc);
                  chk("disp_eblock_id", qif.disp_eblock_id, s.did);
               end
               chk("mispredict_valid", qif.mispredict_valid, s.mv);
               if (s.mv) chk("mispredict_cta_id", qif.mispredict_cta_id, s.mcta);
            end
            if (qif.commit_valid) begin
               if (cq.size() == 0) chk("commit_unexpected", qif.commit_valid, 0);
               else begin
                  c = cq.pop_front();
                  chk("commit_eblock_id", qif.commit_eblock_id, c.id);
                  chk("commit_cta_id", qif.commit_cta_id, c.cta);
                  chk("commit_squashed", qif.commit_squashed, c.sq);
               end
            end else if (cq.size() > 0) begin
               chk("commit_missing", qif.commit_valid, 1);
               void'(cq.pop_front());
            end
         end
      end
   end

   // One cycle: derive expected outputs from the model, drive inputs, advance the model.
   task automatic step(input bit iv, input int cta, input logic [31:0] pc, input int id,
                       input bit pred, input bit dr, input bit dv, input int did, input bit dm);
      st_t s;
      int  k, j, hcta;
      bit  cv, mp, acc;
      @(negedge clk);
      s = '{default: '0};
      k = -1;
      foreach (mq[i]) if (k < 0 && !mq[i].disp) k = i;
      s.rdy = (mq.size() < MAX_EBLOCK);
      s.occ = mq.size();
      s.dv  = (k >= 0) && !mq[k].squash;
      if (s.dv) begin
         s.dcta = mq[k].cta;
         s.dpc  = mq[k].pc;
         s.did  = mq[k].id;
      end
      cv   = (mq.size() > 0) && (mq[0].done || (mq[0].squash && mq[0].skip));
      mp   = cv && mq[0].done && mq[0].mis && mq[0].pred && !mq[0].squash;
      hcta = (mq.size() > 0) ? mq[0].cta : -1;
      s.mv   = mp;
      s.mcta = mp ? hcta : 0;
      stq.push_back(s);
      if (cv) cq.push_back('{id: mq[0].id, cta: mq[0].cta, sq: mq[0].squash});

      qif.in_valid        = iv;
      qif.in_cta_id       = CTA_ID_WIDTH'(cta);
      qif.in_pc           = pc;
      qif.in_eblock_id    = EBLOCK_ID_WIDTH'(id);
      qif.in_predicted    = pred;
      qif.disp_ready      = dr;
      qif.done_valid      = dv;
      qif.done_eblock_id  = EBLOCK_ID_WIDTH'(did);
      qif.done_mispredict = dm;

      acc = iv && s.rdy;
      if (dv) begin
         j = -1;
         foreach (mq[i])
            if (j < 0 && mq[i].id == did && mq[i].disp && !mq[i].skip && !mq[i].done) j = i;
         if (j >= 0) begin
            mq[j].done = 1;
            mq[j].mis  = dm;
         end
      end
      if (k >= 0) begin
         if (mq[k].squash) begin
            mq[k].disp = 1;
            mq[k].skip = 1;
         end else if (dr) mq[k].disp = 1;
      end
      if (mp) for (int i = 1; i < mq.size(); i++) if (mq[i].cta == hcta) mq[i].squash = 1;
      if (cv) void'(mq.pop_front());
      if (acc) mq.push_back('{cta: cta, pc: pc, id: id, pred: pred, mis: 0,
                              squash: (mp && cta == hcta), disp: 0, skip: 0, done: 0});
   endtask

   task automatic idle(input bit dr);
      step(0, 0, 32'h0, 0, 0, dr, 0, 0, 0);
   endtask

   task automatic enq(input int cta, input logic [31:0] pc, input int id, input bit pred, input bit dr);
      step(1, cta, pc, id, pred, dr, 0, 0, 0);
   endtask

   task automatic done(input int id, input bit mis, input bit dr);
      step(0, 0, 32'h0, 0, 0, dr, 1, id, mis);
   endtask

   function automatic int pick_done();
      int el[$];
      foreach (mq[i]) if (mq[i].disp && !mq[i].skip && !mq[i].done) el.push_back(mq[i].id);
      if (el.size() == 0) return -1;
      return el[$urandom_range(el.size() - 1)];
   endfunction

   task automatic drain();
      int d;
      for (int n = 0; n < 300 && mq.size() > 0; n++) begin
         d = pick_done();
         step(0, 0, 32'h0, 0, 0, 1, d >= 0, (d < 0) ? 0 : d, 0);
      end
      if (mq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d live entries expected 0", mq.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, qif.in_ready, 1);
      chk({tag, "_occupancy"}, qif.occupancy, 0);
      chk({tag, "_disp_valid"}, qif.disp_valid, 0);
      chk({tag, "_disp_pc"}, qif.disp_pc, 0);
      chk({tag, "_commit_valid"}, qif.commit_valid, 0);
      chk({tag, "_commit_eblock_id"}, qif.commit_eblock_id, 0);
      chk({tag, "_mispredict_valid"}, qif.mispredict_valid, 0);
   endtask

   initial begin : driver
      int          d, cta, id;
      bit          iv, acc;
      logic [31:0] pc;
      qif.in_valid = 0; qif.in_cta_id = '0; qif.in_pc = '0; qif.in_eblock_id = '0;
      qif.in_predicted = 0; qif.disp_ready = 0; qif.done_valid = 0;
      qif.done_eblock_id = '0; qif.done_mispredict = 0;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      mon_en = 1;
      idle(0);

      // single e-block
      enq(1, 32'h100, 0, 0, 1);
      idle(1);
      done(0, 0, 1);
      idle(1);
      idle(1);

      // out-of-order completion, in-order retirement
      enq(0, 32'h200, 0, 0, 1);
      enq(1, 32'h204, 1, 0, 1);
      enq(3, 32'h208, 2, 0, 1);
      idle(1);
      idle(1);
      done(2, 0, 1);
      done(1, 0, 1);
      done(0, 0, 1);
      repeat (4) idle(1);

      // full queue, wrap of the allocation pointer
      for (int i = 0; i < MAX_EBLOCK; i++) enq(i % 4, 32'h300 + 4 * i, i, 0, 0);
      enq(2, 32'h3ff, 0, 0, 0);
      repeat (MAX_EBLOCK) idle(1);
      done(0, 0, 1);
      idle(1);
      enq(3, 32'h400, 0, 0, 1);
      drain();

      // mispredict squashes younger same-CTA entries only
      enq(2, 32'h500, 3, 1, 0);
      enq(2, 32'h504, 4, 0, 1);
      enq(2, 32'h508, 5, 0, 1);
      enq(0, 32'h50c, 6, 0, 0);
      done(3, 1, 0);
      idle(0);
      idle(0);
      idle(1);
      done(4, 0, 1);
      done(6, 0, 1);
      repeat (3) idle(1);
      drain();

      // spurious completion on an empty queue
      done(7, 0, 1);
      done(7, 1, 1);
      idle(1);

      // randomized traffic
      nid = 0;
      for (int n = 0; n < 1500; n++) begin
         iv  = ($urandom % 3) != 0;
         cta = $urandom_range(MAX_NUM_CTA - 1);
         pc  = $urandom;
         id  = nid;
         acc = iv && (mq.size() < MAX_EBLOCK);
         d   = pick_done();
         if (($urandom % 20) == 0) d = $urandom_range(MAX_EBLOCK - 1);
         step(iv, cta, pc, id, ($urandom % 4) == 0, ($urandom % 4) != 0,
              (d >= 0) && ($urandom % 2), (d < 0) ? 0 : d, ($urandom % 3) == 0);
         if (acc) nid = (nid + 1) % MAX_EBLOCK;
      end
      drain();

      // asynchronous reset with live entries
      for (int i = 0; i < 5; i++) enq(i % 4, 32'h600 + 4 * i, i, 0, i < 2);
      idle(0);
      @(negedge clk);
      mon_en = 0;
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      mq.delete();
      stq.delete();
      cq.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1;
      repeat (3) idle(1);
      enq(3, 32'h700, 2, 0, 1);
      idle(1);
      done(2, 0, 1);
      repeat (2) idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eblock_inflight_queue.md
# eblock_inflight_queue

In-order tracking queue between the CTA scheduler and the CGRA fetch/dispatch stage. Accepts scheduled e-blocks (CTA, PC, e-block ID, predicted flag), dispatches them downstream in order, collects out-of-order completions from writeback, and retires them in allocation order. Retirement drives the scheduler's e-block commit port. A mispredicted predicted e-block squashes all younger e-blocks of the same CTA.

## Interface
- MAX_NUM_CTA, 4, hardware CTA slots; CTA_ID_WIDTH = $clog2(MAX_NUM_CTA)
- PC_WIDTH, 32, PC width
- MAX_EBLOCK, 8, e-block IDs and queue depth; power of two; EBLOCK_ID_WIDTH = $clog2(MAX_EBLOCK)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  scheduled e-block offered
- in_ready  out  1  queue not full
- in_cta_id  in  CTA_ID_WIDTH  hardware CTA
- in_pc  in  PC_WIDTH  e-block PC
- in_eblock_id  in  EBLOCK_ID_WIDTH  allocated e-block ID
- in_predicted  in  1  CTA was branch-resolving (speculative)
- disp_valid  out  1  e-block ready for fetch
- disp_ready  in  1  fetch accepts
- disp_cta_id / disp_pc / disp_eblock_id  out  as in_*  dispatched entry fields
- done_valid  in  1  e-block finished execution
- done_eblock_id  in  EBLOCK_ID_WIDTH  finished e-block
- done_mispredict  in  1  branch outcome differs from prediction
- commit_valid  out  1  head retires (to scheduler eblock_commit_valid)
- commit_eblock_id  out  EBLOCK_ID_WIDTH  retired ID
- commit_cta_id  out  CTA_ID_WIDTH  retired CTA
- commit_squashed  out  1  retired entry was squashed
- mispredict_valid  out  1  one-cycle pulse to SIMT stack
- mispredict_cta_id  out  CTA_ID_WIDTH  CTA to redirect
- occupancy  out  EBLOCK_ID_WIDTH+1  live entries

## Operation
- Circular buffer, MAX_EBLOCK entries; head (retire), disp (dispatch), tail (allocate) pointers, each EBLOCK_ID_WIDTH bits, wrap modulo MAX_EBLOCK; occupancy counter disambiguates full/empty.
- Entry fields: valid, dispatched, done, squash, mispredict, predicted, cta_id, pc, eblock_id.
- Enqueue: in_valid && in_ready writes tail, tail+1. in_ready = occupancy != MAX_EBLOCK.
- Dispatch: entry at disp with valid && !dispatched. If squash=0: disp_valid=1; on disp_ready set dispatched, disp+1. If squash=1: no disp_valid; disp+1 silently, entry marked dispatched-skipped (never issued).
- Completion: done_valid for a valid, dispatched, not-done entry matching done_eblock_id sets done and mispredict. Any other done is ignored (simulation error).
- Retire: head valid && (done || (squash && skipped)) -> commit_valid, fields from head, commit_squashed=squash; clear entry, head+1. One retire per cycle.
- Mispredict: retiring head with done && mispredict && predicted && !squash -> mispredict_valid=1, mispredict_cta_id=head cta; at the same edge set squash on every younger valid entry with that cta_id, and on an entry enqueued that cycle with that cta_id.
- Squashed entries already dispatched still wait for done before retiring (hardware still occupied).
- done_mispredict on a non-predicted entry: ignored for squash purposes.

## Timing
- Reset: all entries invalid, pointers 0, occupancy 0; disp_valid, commit_valid, mispredict_valid 0; all data outputs 0; in_ready 1. Reset mid-operation discards all entries, no commits emitted.
- Outputs combinational from registered state; no input-to-output combinational path except disp_* fields independent of disp_ready.
- Enqueue at edge N -> disp_valid earliest cycle N+1.
- done at edge N -> commit_valid earliest cycle N+1.
- Enqueue and retire same cycle: occupancy unchanged; accepted when full only if... no: in_ready uses pre-retire occupancy (no bypass).
- done for head in the retire cycle of a different entry: independent; one retire per cycle.

## Structure
- Shared package cgra_sched_pkg: eblock entry struct typedef, CTA_ID/EBLOCK_ID width localparams, shared with cta_scheduler.
- No sub-module; entry array and pointer logic in one module.

## Test plan
- Single e-block: enqueue CTA 1 PC 0x100 ID 0, disp_ready=1, done ID 0 -> disp cycle after enqueue, commit_valid ID 0 cycle after done, commit_squashed=0.
- Out-of-order done: IDs 0,1,2 dispatched, done 2,1,0 in consecutive cycles -> commits 0,1,2 in order, starting cycle after done 0.
- Full: 8 enqueues, no done -> in_ready=0, occupancy=8; one retire -> in_ready=1 next cycle; tail wraps 7->0.
- Mispredict: CTA 2 predicted ID 3, younger CTA 2 IDs 4 (dispatched), 5 (undispatched), CTA 0 ID 6; done 3 mispredict -> mispredict_valid CTA 2; 5 never dispatched, commits squashed; 4 commits squashed after its done; 6 commits normally.
- Spurious done: done ID 7 with empty queue -> no state change, no commit.
- Async reset with 5 live entries -> outputs zero immediately, in_ready=1, occupancy=0.
